// File: rtl/dsp_pkg.sv
// Shared DSP definitions: default sample width, upsampler FSM states and
// accumulator width helper.
package dsp_pkg;

  localparam int WIDTH_DEFAULT = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } state_e;

  // Accumulator holds A*2^L plus up to (2^L-1) signed deltas of width+1 bits.
  function automatic int ACC_W(input int width, input int log2);
    return width + log2 + 1;
  endfunction

endpackage

// File: rtl/interp_ramp.sv
// Incremental linear ramp: acc starts at base*2^L and advances by delta per
// step; the integer part of acc is the interpolated sample.
module interp_ramp
  import dsp_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int N_LOG2 = 10
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH:0]   delta_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] sample_o,
  output logic             wrap_o
);

  localparam int AW = ACC_W(WIDTH, N_LOG2);

  logic [AW-1:0]     acc_q, acc_d;
  logic [WIDTH:0]    delta_q, delta_d;
  logic [N_LOG2-1:0] k_q, k_d;

  // Load takes priority so a segment change on the wrap step restarts cleanly.
  always_comb begin
    acc_d   = acc_q;
    delta_d = delta_q;
    k_d     = k_q;
    if (load_i) begin
      acc_d   = {base_i[WIDTH-1], base_i, {N_LOG2{1'b0}}};
      delta_d = delta_i;
      k_d     = {N_LOG2{1'b0}};
    end else if (step_i) begin
      acc_d = acc_q + {{N_LOG2{delta_q[WIDTH]}}, delta_q};
      k_d   = k_q + {{(N_LOG2-1){1'b0}}, 1'b1};
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      acc_q   <= {AW{1'b0}};
      delta_q <= {(WIDTH+1){1'b0}};
      k_q     <= {N_LOG2{1'b0}};
    end else begin
      acc_q   <= acc_d;
      delta_q <= delta_d;
      k_q     <= k_d;
    end
  end

  // Arithmetic slice of a two's complement value is floor division by 2^L.
  assign sample_o = acc_q[WIDTH-1+N_LOG2:N_LOG2];
  assign wrap_o   = (k_q == {N_LOG2{1'b1}});

endmodule

// File: rtl/lin_interp_up.sv
// Linear-interpolating upsampler: 2^N_LOG2 output points per input interval,
// valid/ready input with a one-deep pending buffer and sticky underrun flag.
module lin_interp_up
  import dsp_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int N_LOG2 = 10
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] signal_out,
  output logic             out_valid,
  output logic             underrun
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic             p_valid_q, p_valid_d;
  logic [WIDTH-1:0] signal_out_q, signal_out_d;
  logic             out_valid_q, out_valid_d;
  logic             underrun_q, underrun_d;

  logic             xfer_s;
  logic [WIDTH-1:0] next_s;
  logic             ramp_load_s, ramp_step_s, ramp_wrap_s;
  logic [WIDTH-1:0] ramp_base_s, ramp_sample_s;
  logic [WIDTH:0]   ramp_delta_s;

  function automatic logic [WIDTH:0] diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] base);
    return {x[WIDTH-1], x} - {base[WIDTH-1], base};
  endfunction

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE, PRIME, STALL: in_ready = 1'b1;
        RUN:                in_ready = !p_valid_q;
        default:            in_ready = 1'b0;
      endcase
    end else begin
      in_ready = 1'b0;
    end
  end

  assign xfer_s = in_valid & in_ready;
  // Pending sample wins; otherwise a same-cycle transfer bypasses P.
  assign next_s = p_valid_q ? p_q : in_sample;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    p_d          = p_q;
    p_valid_d    = p_valid_q;
    signal_out_d = signal_out_q;
    out_valid_d  = 1'b0;
    underrun_d   = underrun_q;
    ramp_load_s  = 1'b0;
    ramp_step_s  = 1'b0;
    ramp_base_s  = b_q;
    ramp_delta_s = diff(next_s, b_q);
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          a_d     = in_sample;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (xfer_s) begin
          b_d          = in_sample;
          ramp_load_s  = 1'b1;
          ramp_base_s  = a_q;
          ramp_delta_s = diff(in_sample, a_q);
          state_d      = RUN;
        end
      end
      RUN: begin
        if (xfer_s) begin
          p_d       = in_sample;
          p_valid_d = 1'b1;
        end
        if (enable) begin
          signal_out_d = ramp_sample_s;
          out_valid_d  = 1'b1;
          if (!ramp_wrap_s) begin
            ramp_step_s = 1'b1;
          end else if (p_valid_q || xfer_s) begin
            a_d         = b_q;
            b_d         = next_s;
            ramp_load_s = 1'b1;
            p_valid_d   = 1'b0;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (enable) begin
          signal_out_d = b_q;
          out_valid_d  = 1'b1;
          underrun_d   = 1'b1;
        end
        if (xfer_s) begin
          a_d         = b_q;
          b_d         = in_sample;
          ramp_load_s = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      p_q          <= {WIDTH{1'b0}};
      p_valid_q    <= 1'b0;
      signal_out_q <= {WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      p_q          <= p_d;
      p_valid_q    <= p_valid_d;
      signal_out_q <= signal_out_d;
      out_valid_q  <= out_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  interp_ramp #(
    .WIDTH (WIDTH),
    .N_LOG2(N_LOG2)
  ) u_ramp (
    .clock_in(clock_in),
    .reset   (reset),
    .load_i  (ramp_load_s),
    .base_i  (ramp_base_s),
    .delta_i (ramp_delta_s),
    .step_i  (ramp_step_s),
    .sample_o(ramp_sample_s),
    .wrap_o  (ramp_wrap_s)
  );

  assign signal_out = signal_out_q;
  assign out_valid  = out_valid_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_lin_interp_up.sv
// Self-checking bench: scoreboard for an N_LOG2=2 instance, directed extreme
// and backpressure checks for an N_LOG2=10 instance.
module tb_lin_interp_up;

  localparam int W = 28;
  localparam longint MAXV = 134217727;
  localparam longint MINV = -134217728;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset2, enable2, valid2, ready2, ov2, ur2;
  logic [W-1:0]  samp2, out2;
  logic          reset10, enable10, valid10, ready10, ov10, ur10;
  logic [W-1:0]  samp10, out10;

  int checks = 0;
  int errors = 0;

  longint exp_q[$];
  longint prev_smp;
  bit     have_prev;
  longint stall_exp = 0;
  int     out_cnt2 = 0;
  bit     toggle2 = 1'b0;
  logic   en_edge2;

  int     cnt10 = 0;
  longint first10 = 0, last10 = 0, prev10 = 0;
  int     mono_bad10 = 0;

  lin_interp_up #(.WIDTH(W), .N_LOG2(2)) dut2 (
    .clock_in(clk), .reset(reset2), .enable(enable2),
    .in_sample(samp2), .in_valid(valid2), .in_ready(ready2),
    .signal_out(out2), .out_valid(ov2), .underrun(ur2)
  );

  lin_interp_up #(.WIDTH(W), .N_LOG2(10)) dut10 (
    .clock_in(clk), .reset(reset10), .enable(enable10),
    .in_sample(samp10), .in_valid(valid10), .in_ready(ready10),
    .signal_out(out10), .out_valid(ov10), .underrun(ur10)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic longint floor_div4(input longint num);
    longint q;
    q = num / 4;
    if ((num % 4 != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  task automatic send2(input longint x);
    int t = 0;
    @(negedge clk);
    valid2 = 1'b1;
    samp2  = x[W-1:0];
    while (!ready2 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ready2) begin
      chk("send2_timeout", 1, 0);
      valid2 = 1'b0;
    end else begin
      @(posedge clk);
      #2;
      valid2 = 1'b0;
      if (have_prev) begin
        for (int k = 0; k < 4; k++)
          exp_q.push_back(floor_div4(prev_smp * 4 + longint'(k) * (x - prev_smp)));
      end
      prev_smp  = x;
      have_prev = 1'b1;
      stall_exp = x;
    end
  endtask

  task automatic send10(input longint x);
    int t = 0;
    @(negedge clk);
    valid10 = 1'b1;
    samp10  = x[W-1:0];
    while (!ready10 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!ready10) chk("send10_timeout", 1, 0);
    @(posedge clk);
    #2;
    valid10 = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset2();
    @(negedge clk);
    reset2 = 1'b1;
    exp_q.delete();
    have_prev = 1'b0;
    repeat (2) @(negedge clk);
    reset2 = 1'b0;
  endtask

  always @(negedge clk) if (toggle2) enable2 = !enable2;

  // Scoreboard for the N_LOG2=2 instance; an empty queue means STALL hold.
  always @(posedge clk) begin
    longint e;
    en_edge2 = enable2;
    #1;
    if (en_edge2 !== 1'b1) chk("ov_gated", ov2, 0);
    if (ov2 === 1'b1) begin
      out_cnt2++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out", $signed(out2), e);
      end else begin
        chk("stall_out", $signed(out2), stall_exp);
        chk("stall_underrun", ur2, 1);
      end
    end
  end

  always @(posedge clk) begin
    longint v;
    #1;
    if (ov10 === 1'b1) begin
      v = $signed(out10);
      if (cnt10 < 1024) begin
        if (cnt10 == 0) first10 = v;
        else if (v > prev10) mono_bad10++;
        if (cnt10 == 1023) last10 = v;
        prev10 = v;
      end
      cnt10++;
    end
  end

  initial begin
    int base;
    int t;
    longint num, lastexp;
    reset2 = 1'b1; enable2 = 1'b1; valid2 = 1'b1; samp2 = 28'd123;
    reset10 = 1'b1; enable10 = 1'b0; valid10 = 1'b0; samp10 = 28'd0;
    have_prev = 1'b0; prev_smp = 0;

    repeat (3) @(negedge clk);
    chk("rst_ready", ready2, 0);
    chk("rst_out", out2, 0);
    chk("rst_ov", ov2, 0);
    chk("rst_underrun", ur2, 0);
    valid2 = 1'b0;
    reset2 = 1'b0;
    #1;
    chk("idle_ready", ready2, 1);

    send2(0); send2(400); send2(400); send2(400);
    wait_drain();
    chk("ramp_underrun", ur2, 0);
    do_reset2();

    send2(0); send2(-3); send2(-3);
    wait_drain();
    do_reset2();

    send2(0); send2(400);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("underrun_set", ur2, 1);
    send2(0);
    wait_drain();
    chk("underrun_sticky", ur2, 1);
    do_reset2();

    toggle2 = 1'b1;
    send2(0); send2(400); send2(400); send2(400);
    wait_drain();
    chk("toggle_underrun", ur2, 0);
    toggle2 = 1'b0;
    enable2 = 1'b1;
    do_reset2();

    send2(0); send2(400);
    base = out_cnt2;
    t = 0;
    while (out_cnt2 < base + 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_reach_k2", out_cnt2, base + 2);
    do_reset2();
    chk("midrst_underrun", ur2, 0);
    send2(1000);
    base = out_cnt2;
    repeat (6) @(negedge clk);
    chk("midrst_no_output", out_cnt2, base);
    send2(2000);
    wait_drain();
    do_reset2();

    @(negedge clk);
    reset10 = 1'b0;
    enable10 = 1'b1;
    send10(MAXV);
    send10(MINV);
    send10(5);
    @(negedge clk);
    chk("bp_ready_drop", ready10, 0);
    valid10 = 1'b1;
    samp10 = 28'd7;
    t = 0;
    while (!ready10 && t < 1200) begin
      @(negedge clk);
      t++;
    end
    chk("bp_rise_after_wrap", cnt10, 1024);
    @(posedge clk);
    #2;
    valid10 = 1'b0;
    num = MAXV * 1024 + 1023 * (MINV - MAXV);
    lastexp = num / 1024;
    if ((num % 1024 != 0) && (num < 0)) lastexp = lastexp - 1;
    chk("ext_first", first10, MAXV);
    chk("ext_last", last10, lastexp);
    chk("ext_monotonic", mono_bad10, 0);
    chk("ext_underrun", ur10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
